uart_tx_arbiter: RTL and testbench

//  Shares a single uart_tx transmitter between NUM_REQ requesters (bus masters / debug ports).

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the shared transmitter arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned DATA_LEN = 8
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*DATA_LEN-1:0] req_data;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          ack;
    logic                        err;
    logic                        send_sig;
    logic [DATA_LEN-1:0]         tx_data_out;
    logic                        tx_busy;
    logic                        tx_done;

    modport master (
        output req, req_data, tx_busy, tx_done,
        input  grant, ack, err, send_sig, tx_data_out
    );

    modport slave (
        input  req, req_data, tx_busy, tx_done,
        output grant, ack, err, send_sig, tx_data_out
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ requesters, with a
// watchdog that aborts a transfer whose tx_done never arrives.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned DATA_LEN       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 40000
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                err_q, err_d;
    logic                send_q, send_d;
    logic [DATA_LEN-1:0] data_q, data_d;

    logic                found_c;
    logic [PTR_W-1:0]    win_c;
    int unsigned         idx_c;
    logic [DATA_LEN-1:0] req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = bus.req_data[g*DATA_LEN +: DATA_LEN];
    end

    // First requesting index after the last winner, wrapping modulo NUM_REQ.
    always_comb begin : arb_scan
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx_c = 32'(ptr_q) + k;
            if (idx_c >= NUM_REQ) idx_c = idx_c - NUM_REQ;
            if (!found_c && bus.req[PTR_W'(idx_c)]) begin
                found_c = 1'b1;
                win_c   = PTR_W'(idx_c);
            end
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        grant_d = grant_q;
        ack_d   = '0;
        err_d   = 1'b0;
        send_d  = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (found_c && !bus.tx_busy) begin
                    grant_d = NUM_REQ'(1) << win_c;
                    data_d  = req_bytes[win_c];
                    ptr_d   = win_c;
                    state_d = SEND;
                end
            end
            SEND: begin
                send_d  = 1'b1;
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Saturating so a stuck count can never wrap back below the limit.
                wd_d = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);
                if (bus.tx_done) begin
                    state_d = DONE;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                ack_d   = grant_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin : fsm_regs
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            wd_q    <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            send_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            send_q  <= send_d;
            data_q  <= data_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.ack         = ack_q;
    assign bus.err         = err_q;
    assign bus.send_sig    = send_q;
    assign bus.tx_data_out = data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, hand-timed corner sequences and
// randomized request streams against a round-robin reference model.
module tb_uart_tx_arbiter;
    localparam int unsigned NR = 3;
    localparam int unsigned DL = 8;
    localparam int unsigned TO = 100;

    logic clk;
    logic reset;
    logic stub_done;
    logic stub_busy;
    logic force_busy;
    int   done_delay;
    int   stub_cnt;

    int checks   = 0;
    int failures = 0;
    int n_send   = 0;
    int n_ack    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int send_cyc = 0;
    int ack_cyc  = 0;
    int err_cyc  = 0;
    logic [NR-1:0] last_grant;
    logic [NR-1:0] last_ack;
    logic [DL-1:0] last_data;

    int            s_cnt [NR];
    logic [DL-1:0] s_dat [NR][4];

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_LEN(DL)) bus ();

    assign bus.tx_busy = stub_busy | force_busy;
    assign bus.tx_done = stub_done;

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .DATA_LEN      (DL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor, sampled 2ns after each rising edge.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (bus.send_sig) begin
            n_send++;
            send_cyc   = cyc;
            last_grant = bus.grant;
            last_data  = bus.tx_data_out;
        end
        if (|bus.ack) begin
            n_ack++;
            ack_cyc  = cyc;
            last_ack = bus.ack;
        end
        if (bus.err) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    // uart_tx stand-in: tx_done pulses done_delay cycles after send_sig (never if negative).
    always @(negedge clk) begin
        stub_done = 1'b0;
        if (reset) begin
            stub_cnt = -1;
        end else if (stub_cnt == 0) begin
            stub_done = 1'b1;
            stub_cnt  = -1;
        end else if (stub_cnt > 0) begin
            stub_cnt--;
        end else if (bus.send_sig && done_delay >= 0) begin
            if (done_delay == 0) stub_done = 1'b1;
            else                 stub_cnt  = done_delay - 1;
        end
        stub_busy = (stub_cnt >= 0) || stub_done;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "global watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_end(input int budget, output bit timed_out);
        int a0;
        int e0;
        a0 = n_ack;
        e0 = n_err;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_ack != a0 || n_err != e0) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (timed_out) begin
            checks++;
            failures++;
            $display("FAIL wait_end: no ack or err within %0d cycles", budget);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset   = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    function automatic int rr_pick(input logic [NR-1:0] pend, input int ptr);
        for (int k = 1; k <= int'(NR); k++) begin
            if (pend[(ptr + k) % int'(NR)]) return (ptr + k) % int'(NR);
        end
        return -1;
    endfunction

    // Requesters hold req until ack and re-request at once while bytes remain.
    task automatic run_stream(input string tag);
        int rem [NR];
        int pos [NR];
        int ptr;
        int total;
        int w;
        int s0;
        int e0;
        bit to;
        logic [NR-1:0] pend;
        ptr   = int'(NR) - 1;
        total = 0;
        @(negedge clk);
        for (int i = 0; i < int'(NR); i++) begin
            rem[i] = s_cnt[i];
            pos[i] = 0;
            total += rem[i];
            bus.req[i] = (rem[i] > 0);
            bus.req_data[i*DL +: DL] = s_dat[i][0];
        end
        done_delay = int'($urandom_range(0, 15));
        for (int t = 0; t < total; t++) begin
            for (int i = 0; i < int'(NR); i++) pend[i] = (rem[i] > 0);
            w  = rr_pick(pend, ptr);
            s0 = n_send;
            e0 = n_err;
            wait_end(300, to);
            if (to) break;
            check($sformatf("%s[%0d] sends", tag, t), 32'(n_send - s0), 32'd1);
            check($sformatf("%s[%0d] grant", tag, t), 32'(last_grant), 32'(NR'(1) << w));
            check($sformatf("%s[%0d] data", tag, t), 32'(last_data), 32'(s_dat[w][pos[w]]));
            check($sformatf("%s[%0d] ack", tag, t), 32'(last_ack), 32'(NR'(1) << w));
            check($sformatf("%s[%0d] no_err", tag, t), 32'(n_err - e0), 32'd0);
            rem[w]--;
            pos[w]++;
            ptr = w;
            bus.req[w] = (rem[w] > 0);
            if (rem[w] > 0) bus.req_data[w*DL +: DL] = s_dat[w][pos[w]];
            done_delay = int'($urandom_range(0, 15));
        end
        bus.req = '0;
        repeat (5) @(negedge clk);
    endtask

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*DL-1:0] data;
        int               delay;
        logic [NR-1:0]    exp_grant;
        logic [DL-1:0]    exp_data;
        bit               exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        bit to;
        int s0;
        int a0;
        int e0;

        vecs[0] = '{3'b001, 24'h0000A5,  50, 3'b001, 8'hA5, 1'b0};
        vecs[1] = '{3'b111, 24'h332211,   5, 3'b010, 8'h22, 1'b0};
        vecs[2] = '{3'b101, 24'h665544,   3, 3'b100, 8'h66, 1'b0};
        vecs[3] = '{3'b011, 24'h998877,   7, 3'b001, 8'h77, 1'b0};
        vecs[4] = '{3'b010, 24'h00C300,  -1, 3'b010, 8'hC3, 1'b1};
        vecs[5] = '{3'b001, 24'h00000F,   4, 3'b001, 8'h0F, 1'b0};
        vecs[6] = '{3'b110, 24'hBBAA00,   0, 3'b010, 8'hAA, 1'b0};
        vecs[7] = '{3'b100, 24'h5A0000,  99, 3'b100, 8'h5A, 1'b0};
        vecs[8] = '{3'b001, 24'h00003C, 100, 3'b001, 8'h3C, 1'b1};
        vecs[9] = '{3'b101, 24'hE100E0,   2, 3'b100, 8'hE1, 1'b0};

        reset        = 1'b1;
        force_busy   = 1'b0;
        done_delay   = 50;
        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        check("reset grant", 32'(bus.grant), 32'd0);
        check("reset ack", 32'(bus.ack), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        check("reset send_sig", 32'(bus.send_sig), 32'd0);
        check("reset tx_data_out", 32'(bus.tx_data_out), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            s0 = n_send;
            a0 = n_ack;
            e0 = n_err;
            @(negedge clk);
            done_delay   = vecs[i].delay;
            bus.req_data = vecs[i].data;
            bus.req      = vecs[i].req;
            wait_end(300, to);
            bus.req = '0;
            repeat (6) @(negedge clk);
            check($sformatf("vec%0d sends", i), 32'(n_send - s0), 32'd1);
            check($sformatf("vec%0d grant", i), 32'(last_grant), 32'(vecs[i].exp_grant));
            check($sformatf("vec%0d data", i), 32'(last_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d acks", i), 32'(n_ack - a0), vecs[i].exp_err ? 32'd0 : 32'd1);
            check($sformatf("vec%0d errs", i), 32'(n_err - e0), vecs[i].exp_err ? 32'd1 : 32'd0);
            if (vecs[i].exp_err) begin
                check($sformatf("vec%0d err_latency", i), 32'(err_cyc - send_cyc), 32'(TO));
            end else begin
                check($sformatf("vec%0d ack_value", i), 32'(last_ack), 32'(vecs[i].exp_grant));
                check($sformatf("vec%0d ack_latency", i), 32'(ack_cyc - send_cyc),
                      32'(vecs[i].delay + 2));
            end
        end

        // Cycle-exact grant/send_sig/ack timing.
        @(negedge clk);
        done_delay   = 10;
        bus.req_data = 24'h0000C8;
        bus.req      = 3'b001;
        @(posedge clk); #1;
        check("lat grant", 32'(bus.grant), 32'b001);
        check("lat data", 32'(bus.tx_data_out), 32'hC8);
        check("lat send_lo", 32'(bus.send_sig), 32'd0);
        @(posedge clk); #1;
        check("lat send_hi", 32'(bus.send_sig), 32'd1);
        @(posedge clk); #1;
        check("lat send_end", 32'(bus.send_sig), 32'd0);
        check("lat grant_hold", 32'(bus.grant), 32'b001);
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (bus.tx_done) begin
                to = 1'b0;
                break;
            end
        end
        check("lat tx_done_seen", 32'(to), 32'd0);
        @(posedge clk); #1;
        check("lat ack_wait", 32'(bus.ack), 32'd0);
        check("lat grant_done", 32'(bus.grant), 32'b001);
        @(posedge clk); #1;
        check("lat ack_pulse", 32'(bus.ack), 32'b001);
        check("lat grant_clr", 32'(bus.grant), 32'd0);
        bus.req = '0;
        @(posedge clk); #1;
        check("lat ack_end", 32'(bus.ack), 32'd0);
        repeat (3) @(negedge clk);

        // tx_busy high blocks arbitration.
        s0 = n_send;
        @(negedge clk);
        force_busy   = 1'b1;
        done_delay   = 5;
        bus.req_data = 24'h00005E;
        bus.req      = 3'b001;
        repeat (20) @(negedge clk);
        check("busy no_send", 32'(n_send - s0), 32'd0);
        check("busy grant", 32'(bus.grant), 32'd0);
        force_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("busy send_after", 32'(n_send - s0), 32'd1);
        check("busy data", 32'(last_data), 32'h5E);
        wait_end(300, to);
        bus.req = '0;
        repeat (4) @(negedge clk);

        // Reset while waiting for tx_done.
        s0 = n_send;
        @(negedge clk);
        done_delay   = 30;
        bus.req_data = 24'h009900;
        bus.req      = 3'b010;
        for (int i = 0; i < 20 && n_send == s0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("rst pre_grant", 32'(bus.grant), 32'b010);
        reset = 1'b1;
        #1;
        check("rst grant", 32'(bus.grant), 32'd0);
        check("rst data", 32'(bus.tx_data_out), 32'd0);
        check("rst send_sig", 32'(bus.send_sig), 32'd0);
        check("rst ack", 32'(bus.ack), 32'd0);
        check("rst err", 32'(bus.err), 32'd0);
        bus.req_data = 24'h776600;
        bus.req      = 3'b110;
        repeat (3) @(negedge clk);
        a0 = n_ack;
        e0 = n_err;
        reset = 1'b0;
        wait_end(300, to);
        bus.req = '0;
        repeat (40) @(negedge clk);
        check("rst first_grant", 32'(last_grant), 32'b010);
        check("rst first_data", 32'(last_data), 32'h66);
        check("rst ack_value", 32'(last_ack), 32'b010);
        check("rst ack_count", 32'(n_ack - a0), 32'd1);
        check("rst err_count", 32'(n_err - e0), 32'd0);

        // All three requesting together.
        apply_reset();
        s_cnt[0] = 1; s_cnt[1] = 1; s_cnt[2] = 1;
        s_dat[0][0] = 8'h11; s_dat[1][0] = 8'h22; s_dat[2][0] = 8'h33;
        run_stream("all3");

        // Two requesters re-requesting immediately must alternate.
        apply_reset();
        s_cnt[0] = 3; s_cnt[1] = 0; s_cnt[2] = 3;
        for (int j = 0; j < 3; j++) begin
            s_dat[0][j] = 8'(8'hA0 + j);
            s_dat[2][j] = 8'(8'hC0 + j);
        end
        run_stream("alt");

        for (int r = 0; r < 5; r++) begin
            apply_reset();
            for (int i = 0; i < int'(NR); i++) begin
                s_cnt[i] = int'($urandom_range(0, 3));
                for (int j = 0; j < 4; j++) s_dat[i][j] = 8'($urandom);
            end
            run_stream($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
